// File: rtl/lpf_multi_tdm_if.sv
// Sample/result bus for the time-multiplexed low-pass filter bank.
// master drives samples and controls, slave is the filter.
interface lpf_multi_tdm_if #(
  parameter int DATA_W   = 16,
  parameter int SHR_MAX  = 8,
  parameter int CHANNELS = 4
);
  localparam int SHR_W = $clog2(SHR_MAX + 1);

  logic                       en_i;
  logic [SHR_W-1:0]           shr_i;
  logic                       clr_i;
  logic [CHANNELS*DATA_W-1:0] data_i;
  logic                       busy_o;
  logic                       valid_o;
  logic [CHANNELS*DATA_W-1:0] lp_o;

  modport master (
    output en_i, shr_i, clr_i, data_i,
    input  busy_o, valid_o, lp_o
  );

  modport slave (
    input  en_i, shr_i, clr_i, data_i,
    output busy_o, valid_o, lp_o
  );
endinterface

// File: rtl/lpf_multi_tdm.sv
// Cascade of first-order low-pass filters for many channels.
// One shared subtract/shift/add datapath updates one (channel, stage) pair per cycle.
module lpf_multi_tdm #(
  parameter int DATA_W   = 16,
  parameter int SHR_MAX  = 8,
  parameter int CHANNELS = 4,
  parameter int ORDER    = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  lpf_multi_tdm_if.slave  bus
);
  localparam int ACCUM_W = DATA_W + SHR_MAX;
  localparam int SHR_W   = $clog2(SHR_MAX + 1);
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int STG_W   = (ORDER > 1) ? $clog2(ORDER) : 1;

  localparam logic [SHR_W-1:0] SHR_SAT  = SHR_W'(SHR_MAX);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(ORDER - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     r_fsm;
  logic [ACCUM_W-1:0]         r_state [CHANNELS][ORDER];
  logic [DATA_W-1:0]          r_in    [CHANNELS];
  logic [SHR_W-1:0]           r_shr;
  logic [CH_W-1:0]            r_ch;
  logic [STG_W-1:0]           r_stg;
  logic                       r_busy;
  logic                       r_valid;
  logic [CHANNELS*DATA_W-1:0] r_lp;

  logic [ACCUM_W-1:0]         w_x;
  logic [ACCUM_W-1:0]         w_cur;
  logic [ACCUM_W-1:0]         w_next;
  logic [STG_W-1:0]           w_prevStg;
  logic signed [ACCUM_W:0]    w_diff;
  logic signed [ACCUM_W:0]    w_step;
  logic signed [ACCUM_W:0]    w_sum;

  // Stage g>0 reads stage g-1, which was rewritten on the previous cycle of this pass.
  always_comb begin
    w_prevStg = r_stg - STG_W'(1);
    w_cur     = r_state[r_ch][r_stg];
    if (r_stg == '0) begin
      w_x = {r_in[r_ch], {SHR_MAX{1'b0}}};
    end else begin
      w_x = r_state[r_ch][w_prevStg];
    end
    w_diff = $signed({1'b0, w_x}) - $signed({1'b0, w_cur});
    w_step = w_diff >>> r_shr;
    w_sum  = $signed({1'b0, w_cur}) + w_step;
    w_next = w_sum[ACCUM_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fsm   <= IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_lp    <= '0;
      r_ch    <= '0;
      r_stg   <= '0;
      r_shr   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_in[c] <= '0;
        for (int g = 0; g < ORDER; g++) begin
          r_state[c][g] <= '0;
        end
      end
    end else begin
      r_valid <= 1'b0;
      if (bus.clr_i) begin
        for (int c = 0; c < CHANNELS; c++) begin
          for (int g = 0; g < ORDER; g++) begin
            r_state[c][g] <= '0;
          end
        end
      end
      case (r_fsm)
        IDLE: begin
          if (bus.en_i && !bus.clr_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
              r_in[c] <= bus.data_i[c*DATA_W +: DATA_W];
            end
            r_shr  <= (bus.shr_i > SHR_SAT) ? SHR_SAT : bus.shr_i;
            r_ch   <= '0;
            r_stg  <= '0;
            r_busy <= 1'b1;
            r_fsm  <= RUN;
          end
        end
        RUN: begin
          if (bus.clr_i) begin
            r_busy <= 1'b0;
            r_fsm  <= IDLE;
          end else begin
            r_state[r_ch][r_stg] <= w_next;
            if (r_stg == STG_LAST) begin
              r_stg <= '0;
              if (r_ch == CH_LAST) begin
                // The last channel's final stage is still in flight, so take it from w_next.
                for (int c = 0; c < CHANNELS; c++) begin
                  if (c == CHANNELS - 1) begin
                    r_lp[c*DATA_W +: DATA_W] <= w_next[ACCUM_W-1 -: DATA_W];
                  end else begin
                    r_lp[c*DATA_W +: DATA_W] <= r_state[c][ORDER-1][ACCUM_W-1 -: DATA_W];
                  end
                end
                r_valid <= 1'b1;
                r_fsm   <= DONE;
              end else begin
                r_ch <= r_ch + CH_W'(1);
              end
            end else begin
              r_stg <= r_stg + STG_W'(1);
            end
          end
        end
        DONE: begin
          r_busy <= 1'b0;
          r_fsm  <= IDLE;
        end
        default: begin
          r_busy <= 1'b0;
          r_fsm  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o  = r_busy;
  assign bus.valid_o = r_valid;
  assign bus.lp_o    = r_lp;
endmodule

// File: tb/tb_lpf_multi_tdm.sv
// Directed bench for lpf_multi_tdm with hand-computed filter outputs.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_lpf_multi_tdm;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  lpf_multi_tdm_if #(.DATA_W(16), .SHR_MAX(8), .CHANNELS(4)) bus ();

  lpf_multi_tdm #(.DATA_W(16), .SHR_MAX(8), .CHANNELS(4), .ORDER(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] pack4(input logic [15:0] c0, input logic [15:0] c1,
                                        input logic [15:0] c2, input logic [15:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] data, input logic [3:0] shr);
    bus.data_i = data;
    bus.shr_i  = shr;
    bus.en_i   = 1'b1;
    @(negedge clk);
    bus.en_i   = 1'b0;
  endtask

  task automatic pulseClear();
    bus.clr_i = 1'b1;
    @(negedge clk);
    bus.clr_i = 1'b0;
  endtask

  // Runs one pass; optionally pokes en_i/data_i/shr_i at cycle dCyc while the pass is busy.
  task automatic runPass(input logic [63:0] data, input logic [3:0] shr, input int dCyc,
                         input logic [63:0] dData, input logic [3:0] dShr,
                         output logic [63:0] lp, output int lat);
    applyStimulus(data, shr);
    lat = 1;
    while (bus.valid_o !== 1'b1 && lat < 50) begin
      if (lat == dCyc) begin
        bus.data_i = dData;
        bus.shr_i  = dShr;
        bus.en_i   = 1'b1;
      end else begin
        bus.en_i = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.en_i = 1'b0;
    lp = bus.lp_o;
    @(negedge clk);
  endtask

  task automatic countQuiet(input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.valid_o !== 1'b0) hits++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [63:0] lp;
    logic [63:0] ptData;
    int          lat;
    int          bad;
    int          stepExp [4];

    checks   = 0;
    failures = 0;
    rst        = 1'b1;
    bus.en_i   = 1'b0;
    bus.clr_i  = 1'b0;
    bus.shr_i  = '0;
    bus.data_i = '0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_lp", bus.lp_o, 64'd0);
    checkOutput("reset_busy", {63'd0, bus.busy_o}, 64'd0);
    checkOutput("reset_valid", {63'd0, bus.valid_o}, 64'd0);

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.lp_o !== 64'd0 || bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0) bad++;
    end
    checkOutput("idle_hold", 64'(bad), 64'd0);

    // Pass-through with cycle-exact busy/valid timing.
    $display("[TB] pass-through");
    ptData = pack4(16'h1234, 16'hFFFF, 16'h0000, 16'h8000);
    applyStimulus(ptData, 4'd0);
    bad = 0;
    for (int k = 1; k <= 9; k++) begin
      if (bus.busy_o !== 1'b1) bad++;
      if (bus.valid_o !== (k == 9)) bad++;
      if (k < 9) @(negedge clk);
    end
    checkOutput("pt_timing", 64'(bad), 64'd0);
    checkOutput("pt_lp", bus.lp_o, ptData);
    @(negedge clk);
    checkOutput("pt_busy_end", {62'd0, bus.busy_o, bus.valid_o}, 64'd0);

    // Step response on channel 0, then a step back down to 0.
    $display("[TB] step response");
    pulseClear();
    stepExp = '{250, 500, 687, 812};
    for (int p = 0; p < 4; p++) begin
      runPass(pack4(16'd1000, 16'd0, 16'd0, 16'd0), 4'd1, 0, 64'd0, 4'd0, lp, lat);
      checkOutput($sformatf("step_lat%0d", p), 64'(lat), 64'd9);
      checkOutput($sformatf("step_lp%0d", p), lp, pack4(16'(stepExp[p]), 16'd0, 16'd0, 16'd0));
    end
    runPass(64'd0, 4'd1, 0, 64'd0, 4'd0, lp, lat);
    checkOutput("step_down", lp, pack4(16'd640, 16'd0, 16'd0, 16'd0));

    // Channel independence and a shift change between passes.
    $display("[TB] channel independence");
    pulseClear();
    runPass(pack4(16'd1000, 16'd0, 16'd500, 16'd0), 4'd1, 0, 64'd0, 4'd0, lp, lat);
    checkOutput("ind_p1", lp, pack4(16'd250, 16'd0, 16'd125, 16'd0));
    runPass(pack4(16'd1000, 16'd0, 16'd500, 16'd0), 4'd1, 0, 64'd0, 4'd0, lp, lat);
    checkOutput("ind_p2", lp, pack4(16'd500, 16'd0, 16'd250, 16'd0));
    runPass(pack4(16'd1000, 16'd0, 16'd500, 16'd0), 4'd1, 0, 64'd0, 4'd0, lp, lat);
    checkOutput("ind_p3", lp, pack4(16'd687, 16'd0, 16'd343, 16'd0));
    // data/shr/en changes during this pass must not matter.
    runPass(pack4(16'd1000, 16'd0, 16'd500, 16'd0), 4'd2, 3, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0, lp, lat);
    checkOutput("ind_p4_shr2", lp, pack4(16'd742, 16'd0, 16'd371, 16'd0));
    checkOutput("ind_p4_lat", 64'(lat), 64'd9);

    // Busy rejection: a second en_i mid-pass is ignored entirely.
    $display("[TB] busy rejection");
    pulseClear();
    runPass(pack4(16'd1000, 16'd0, 16'd0, 16'd0), 4'd1, 4,
            pack4(16'd5000, 16'd5000, 16'd5000, 16'd5000), 4'd0, lp, lat);
    checkOutput("busy_lat", 64'(lat), 64'd9);
    checkOutput("busy_lp", lp, pack4(16'd250, 16'd0, 16'd0, 16'd0));
    countQuiet(15, bad);
    checkOutput("busy_no_extra", 64'(bad), 64'd0);
    checkOutput("busy_idle", {63'd0, bus.busy_o}, 64'd0);

    // shr_i above SHR_MAX saturates to 8.
    $display("[TB] shift saturation");
    pulseClear();
    runPass(pack4(16'hFFFF, 16'd0, 16'd0, 16'd0), 4'd15, 0, 64'd0, 4'd0, lp, lat);
    checkOutput("sat_p1", lp, 64'd0);
    runPass(pack4(16'hFFFF, 16'd0, 16'd0, 16'd0), 4'd15, 0, 64'd0, 4'd0, lp, lat);
    checkOutput("sat_p2", lp, pack4(16'd2, 16'd0, 16'd0, 16'd0));

    // clr_i mid-RUN aborts and zeroes state; lp_o keeps its last value.
    $display("[TB] clear abort");
    applyStimulus(pack4(16'd1000, 16'd0, 16'd0, 16'd0), 4'd1);
    repeat (2) @(negedge clk);
    pulseClear();
    checkOutput("clr_busy", {63'd0, bus.busy_o}, 64'd0);
    countQuiet(15, bad);
    checkOutput("clr_no_valid", 64'(bad), 64'd0);
    checkOutput("clr_lp_held", bus.lp_o, pack4(16'd2, 16'd0, 16'd0, 16'd0));
    runPass(pack4(16'd1000, 16'd0, 16'd0, 16'd0), 4'd1, 0, 64'd0, 4'd0, lp, lat);
    checkOutput("clr_first", lp, pack4(16'd250, 16'd0, 16'd0, 16'd0));

    // Reset mid-RUN.
    $display("[TB] reset abort");
    applyStimulus(pack4(16'd1000, 16'd0, 16'd0, 16'd0), 4'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_lp", bus.lp_o, 64'd0);
    checkOutput("rst_busy", {63'd0, bus.busy_o}, 64'd0);
    countQuiet(15, bad);
    checkOutput("rst_no_valid", 64'(bad), 64'd0);
    runPass(pack4(16'd1000, 16'd0, 16'd0, 16'd0), 4'd1, 0, 64'd0, 4'd0, lp, lat);
    checkOutput("rst_first", lp, pack4(16'd250, 16'd0, 16'd0, 16'd0));

    // clr_i together with en_i: sample dropped, state cleared.
    $display("[TB] clear with enable");
    bus.data_i = pack4(16'd1000, 16'd0, 16'd0, 16'd0);
    bus.shr_i  = 4'd1;
    bus.en_i   = 1'b1;
    bus.clr_i  = 1'b1;
    @(negedge clk);
    bus.en_i  = 1'b0;
    bus.clr_i = 1'b0;
    checkOutput("clren_busy", {63'd0, bus.busy_o}, 64'd0);
    countQuiet(12, bad);
    checkOutput("clren_no_valid", 64'(bad), 64'd0);
    runPass(pack4(16'd1000, 16'd0, 16'd0, 16'd0), 4'd1, 0, 64'd0, 4'd0, lp, lat);
    checkOutput("clren_first", lp, pack4(16'd250, 16'd0, 16'd0, 16'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
